pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller for the 5-stage core (IF/ID/EX/MEM/WB). It takes the decoded register usage of the instruction in ID and tracks outstanding loads in a register scoreboard. It also tracks the in-flight writers in a shift pipe. From these it generates the stall, bubble and flush controls that sequence the fetch, decode and execute stages, including flushes from taken branches and traps.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_reg_scoreboard.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller: regid range, load depth default,
// and the writer-pipe entry. CORE_FORWARD_EN selects the forwarding-network build.
`ifndef RF_RANGE
`define RF_RANGE 4:0
`endif

package pipe_hazard_ctrl_pkg;
  localparam int MAX_OUTSTANDING_DEF = 2;
  localparam int NUM_REGS            = 32;
  localparam int WP_DEPTH            = 3;

  typedef logic [`RF_RANGE] regid_t;

  typedef struct packed {
    logic   valid;
    regid_t rd;
  } wp_entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
// Pending-load bitmap for x1..x31; x0 is never pending. Set wins over clear, and the
// effective mask hides a register whose load returns this cycle.
module reg_scoreboard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                set_en,
  input  regid_t              set_id,
  input  logic                clr_en,
  input  regid_t              clr_id,
  output logic [NUM_REGS-1:0] eff_mask
);
  assign eff_mask[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_bit
    logic pend_q, set_hit, clr_hit;
    assign set_hit = set_en && (set_id == regid_t'(i));
    assign clr_hit = clr_en && (clr_id == regid_t'(i));

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)       pend_q <= 1'b0;
      else if (set_hit) pend_q <= 1'b1;
      else if (clr_hit) pend_q <= 1'b0;
    end

    assign eff_mask[i] = pend_q & ~clr_hit;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush controller for the 5-stage core: load scoreboard, in-flight load
// counter and, unless CORE_FORWARD_EN is defined, an EX/MEM/WB writer pipe for RAW stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             id_valid,
  input  logic             id_rs1_read,
  input  logic             id_rs2_read,
  input  logic [`RF_RANGE] id_rs1_regid,
  input  logic [`RF_RANGE] id_rs2_regid,
  input  logic [`RF_RANGE] id_rd_regid,
  input  logic             id_regfile_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_trap,
  input  logic             lsu_rsp_valid,
  input  logic [`RF_RANGE] lsu_rsp_regid,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [2:0]       load_pending_cnt
);
  logic [NUM_REGS-1:0] eff_mask;
  logic [2:0]          cnt_q;
  logic                id_issue, load_issue, rsp_dec, flush_any;
  logic                raw_sb, raw_wp, waw, cap, hazard;

  assign flush_any  = ex_branch_taken | mem_trap;
  assign id_issue   = id_valid & ~id_stall & ~id_flush;
  assign load_issue = id_issue & id_mem_read & id_regfile_write & (id_rd_regid != '0);
  assign rsp_dec    = lsu_rsp_valid & (cnt_q != '0);

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_b    (rst_b),
    .set_en   (load_issue),
    .set_id   (id_rd_regid),
    .clr_en   (lsu_rsp_valid),
    .clr_id   (lsu_rsp_regid),
    .eff_mask (eff_mask)
  );

`ifdef CORE_FORWARD_EN
  assign raw_wp = 1'b0;
`else
  wp_entry_t [WP_DEPTH-1:0] wp_q;
  logic                     wp_load;

  assign wp_load = id_issue & id_regfile_write & (id_rd_regid != '0);

  always_comb begin
    raw_wp = 1'b0;
    for (int i = 0; i < WP_DEPTH; i++) begin
      if (wp_q[i].valid && ((id_rs1_read && wp_q[i].rd == id_rs1_regid) ||
                            (id_rs2_read && wp_q[i].rd == id_rs2_regid)))
        raw_wp = 1'b1;
    end
  end

  // Slot 0 shadows EX; a trap kills the EX instruction as it would move into MEM.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wp_q <= '0;
    end else begin
      wp_q[0] <= wp_load ? '{valid: 1'b1, rd: id_rd_regid} : '0;
      wp_q[1] <= ex_flush ? '0 : wp_q[0];
      for (int i = 2; i < WP_DEPTH; i++) wp_q[i] <= wp_q[i-1];
    end
  end
`endif

  assign raw_sb = (id_rs1_read & eff_mask[id_rs1_regid]) |
                  (id_rs2_read & eff_mask[id_rs2_regid]);
  assign waw    = id_regfile_write & eff_mask[id_rd_regid];
  assign cap    = id_mem_read & (cnt_q == 3'(MAX_OUTSTANDING)) & ~lsu_rsp_valid;
  assign hazard = id_valid & (raw_sb | raw_wp | waw | cap);

  assign id_stall  = hazard & ~flush_any;
  assign if_stall  = id_stall;
  assign ex_bubble = id_stall;
  assign if_flush  = flush_any;
  assign id_flush  = flush_any;
  assign ex_flush  = mem_trap;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      case ({load_issue, rsp_dec})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign load_pending_cnt = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_b) begin
      assert (!(lsu_rsp_valid && cnt_q == '0))
        else $error("lsu response with no load outstanding");
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized check of pipe_hazard_ctrl against a set/queue reference model.
module tb_pipe_hazard_ctrl;
  localparam int MAX = 2;
`ifdef CORE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0, rst_b = 1'b0;
  logic       id_valid, id_rs1_read, id_rs2_read, id_regfile_write, id_mem_read;
  logic [4:0] id_rs1_regid, id_rs2_regid, id_rd_regid, lsu_rsp_regid;
  logic       ex_branch_taken, mem_trap, lsu_rsp_valid;
  logic       if_stall, id_stall, ex_bubble, if_flush, id_flush, ex_flush;
  logic [2:0] load_pending_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid),
    .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_regid(id_rs1_regid), .id_rs2_regid(id_rs2_regid), .id_rd_regid(id_rd_regid),
    .id_regfile_write(id_regfile_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_trap(mem_trap),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_regid(lsu_rsp_regid),
    .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .load_pending_cnt(load_pending_cnt)
  );

  int vectors = 0, miscompares = 0;
  int stall_seen, sum;
  bit pend [32];
  int inflight [$];
  int wp [3];

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    inflight.delete();
    foreach (wp[i]) wp[i] = 0;
  endtask

  task automatic drive(bit v, bit r1r, int r1, bit r2r, int r2, bit wr, int rd, bit mr,
                       bit br, bit tr, bit rv, int rid);
    id_valid = v; id_rs1_read = r1r; id_rs1_regid = 5'(r1);
    id_rs2_read = r2r; id_rs2_regid = 5'(r2);
    id_regfile_write = wr; id_rd_regid = 5'(rd); id_mem_read = mr;
    ex_branch_taken = br; mem_trap = tr; lsu_rsp_valid = rv; lsu_rsp_regid = 5'(rid);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit busy(int r);
    if (r == 0) return 1'b0;
    if (pend[r] && !(lsu_rsp_valid && int'(lsu_rsp_regid) == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_flight_writer(int r);
    if (r == 0 || FWD) return 1'b0;
    foreach (wp[i]) if (wp[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare at the falling edge, then advance the model across the rising edge.
  task automatic step(string tag);
    bit raw, waw, cap, hz, fl, stall, issue;
    int exp, obs, r1, r2, rd;
    r1 = int'(id_rs1_regid); r2 = int'(id_rs2_regid); rd = int'(id_rd_regid);
    @(negedge clk);
    raw = (id_rs1_read && (busy(r1) || in_flight_writer(r1))) ||
          (id_rs2_read && (busy(r2) || in_flight_writer(r2)));
    waw = id_regfile_write && busy(rd);
    cap = id_mem_read && inflight.size() == MAX && !lsu_rsp_valid;
    hz  = id_valid && (raw || waw || cap);
    fl  = ex_branch_taken || mem_trap;
    stall = hz && !fl;
    issue = id_valid && !stall && !fl;
    exp = {23'd0, stall, stall, stall, fl, fl, mem_trap, 3'(inflight.size())};
    obs = {23'd0, if_stall, id_stall, ex_bubble, if_flush, id_flush, ex_flush, load_pending_cnt};
    check(tag, obs, exp);
    stall_seen = int'(id_stall);
    if (rst_b && lsu_rsp_valid) begin
      pend[lsu_rsp_regid] = 1'b0;
      foreach (inflight[i]) if (inflight[i] == int'(lsu_rsp_regid)) begin
        inflight.delete(i);
        break;
      end
    end
    if (rst_b && issue && id_mem_read && id_regfile_write && rd != 0) begin
      pend[rd] = 1'b1;
      inflight.push_back(rd);
    end
    wp[2] = wp[1];
    wp[1] = mem_trap ? 0 : wp[0];
    wp[0] = (rst_b && issue && id_regfile_write) ? rd : 0;
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle();
    bit rv;
    int rid;
    rv = inflight.size() > 0 && $urandom_range(99) < 35;
    rid = rv ? inflight[$urandom_range(inflight.size() - 1)] : 0;
    drive($urandom_range(99) < 80, 1'($urandom_range(1)), $urandom_range(7),
          1'($urandom_range(1)), $urandom_range(7), $urandom_range(99) < 70,
          $urandom_range(7), $urandom_range(99) < 45, $urandom_range(99) < 6,
          $urandom_range(99) < 4, rv, rid);
    step("rand");
  endtask

  initial begin
    model_reset();
    idle();
    step("reset");
    step("reset");
    rst_b = 1'b1;
    step("idle");

    // Load x5 then add x6,x5,x1: stalls 3 cycles, released by the bypassed response.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0); step("ld_x5");
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0); step("use_x5"); sum += stall_seen;
    end
    check("ld_use_stall_cycles", sum, 3);
    drive(1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 1, 5); step("use_x5_rsp");
    check("ld_use_bypass", stall_seen, 0);
    idle(); for (int i = 0; i < 3; i++) step("drain");

    // Capacity: x7, x8 in flight, x9 waits for the first response and issues with it.
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0); step("ld_x7");
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0); step("ld_x8");
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0); step("ld_x9_full");
    check("cap_stall", stall_seen, 1);
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 1, 7); step("ld_x9_rsp");
    check("cap_release", stall_seen, 0);
    idle(); step("cap_hold");
    check("cap_cnt", int'(load_pending_cnt), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8); step("rsp_x8");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step("rsp_x9");
    idle(); for (int i = 0; i < 3; i++) step("drain");

    // Branch kills a stalled consumer; the scoreboard keeps x5.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0); step("ld_x5_b");
    drive(1, 1, 5, 0, 0, 1, 6, 0, 1, 0, 0, 0); step("use_x5_branch");
    check("branch_no_stall", stall_seen, 0);
    drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0, 0); step("use_x5_after_branch");
    check("branch_sb_kept", stall_seen, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5); step("rsp_x5");

    // Trap kills a load to x3; it is never counted.
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 0, 0); step("ld_x3_trap");
    idle(); step("after_trap");
    check("trap_cnt", int'(load_pending_cnt), 0);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("use_x3");

    // Load to x0 then a reader of x0.
    idle(); for (int i = 0; i < 3; i++) step("drain");
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0); step("ld_x0");
    drive(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0); step("use_x0");
    check("x0_no_stall", stall_seen, 0);
    check("x0_cnt", int'(load_pending_cnt), 0);

    // addi x2 then add x4,x2,x2.
    idle(); for (int i = 0; i < 3; i++) step("drain");
    drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0); step("addi_x2");
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2, 1, 2, 1, 4, 0, 0, 0, 0, 0); step("add_x4"); sum += stall_seen;
    end
    check("alu_raw_stall_cycles", sum, FWD ? 0 : 3);

    for (int i = 0; i < 400; i++) rand_cycle();

    // Mid-operation reset clears everything.
    rst_b = 1'b0;
    model_reset();
    idle();
    step("reset_mid");
    step("reset_mid");
    rst_b = 1'b1;
    step("post_reset");
    for (int i = 0; i < 200; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
